// File: rtl/pc_stack_unit.sv
// rtl/pc_stack_unit.sv - program counter with edge-qualified jump/call/return and return-address stack
// Increment, JMP, ACALL and RET with sticky overflow/underflow detection.
module pc_stack_unit #(
  parameter  int ADDR_W = 13,
  parameter  int DEPTH  = 8,
  localparam int SP_W   = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PC_en,
  input  logic              PC_wr,
  input  logic              acall,
  input  logic [ADDR_W-1:0] ir_addr,
  output logic [ADDR_W-1:0] pc_addr,
  output logic [ADDR_W-1:0] ret_addr,
  output logic [SP_W-1:0]   sp,
  output logic              stk_full,
  output logic              stk_empty,
  output logic              stk_err
);

  localparam int IDX_W = SP_W - 1;

  logic [ADDR_W-1:0] stack [DEPTH];
  logic              prev_wr;
  logic              prev_acall;
  logic              fire;
  logic              do_call;
  logic              do_ret;
  logic              do_jmp;
  logic              do_inc;
  logic [SP_W-1:0]   sp_m1;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  top_idx;

  // A strobe acts only on its first asserted cycle; holding it high does nothing more.
  assign fire = (PC_wr & ~prev_wr) | (acall & ~prev_acall);

  always_comb begin
    do_call = 1'b0;
    do_ret  = 1'b0;
    do_jmp  = 1'b0;
    do_inc  = 1'b0;
    if (fire) begin
      do_call = PC_wr & acall;
      do_ret  = ~PC_wr & acall;
      do_jmp  = PC_wr & ~acall;
    end else begin
      do_inc  = PC_en;
    end
  end

  assign sp_m1     = sp - SP_W'(1);
  assign push_idx  = sp[IDX_W-1:0];
  assign top_idx   = sp_m1[IDX_W-1:0];
  assign stk_full  = (sp == SP_W'(DEPTH));
  assign stk_empty = (sp == '0);
  assign ret_addr  = stk_empty ? '0 : stack[top_idx];

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_addr    <= '0;
      sp         <= '0;
      stk_err    <= 1'b0;
      prev_wr    <= 1'b0;
      prev_acall <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        stack[i] <= '0;
      end
    end else begin
      prev_wr    <= PC_wr;
      prev_acall <= acall;
      if (do_call) begin
        if (stk_full) begin
          stk_err <= 1'b1;
        end else begin
          stack[push_idx] <= pc_addr;
          sp              <= sp + SP_W'(1);
          pc_addr         <= ir_addr;
        end
      end else if (do_ret) begin
        if (stk_empty) begin
          stk_err <= 1'b1;
        end else begin
          pc_addr <= stack[top_idx];
          sp      <= sp_m1;
        end
      end else if (do_jmp) begin
        pc_addr <= ir_addr;
      end else if (do_inc) begin
        pc_addr <= pc_addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pc_stack_unit.sv
// tb/tb_pc_stack_unit.sv - directed self-checking bench for pc_stack_unit
module tb_pc_stack_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        PC_en;
  logic        PC_wr;
  logic        acall;
  logic [12:0] ir_addr;
  logic [12:0] pc_addr;
  logic [12:0] ret_addr;
  logic [3:0]  sp;
  logic        stk_full;
  logic        stk_empty;
  logic        stk_err;

  int n_pass  = 0;
  int n_total = 0;

  pc_stack_unit #(.ADDR_W(13), .DEPTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .PC_en    (PC_en),
    .PC_wr    (PC_wr),
    .acall    (acall),
    .ir_addr  (ir_addr),
    .pc_addr  (pc_addr),
    .ret_addr (ret_addr),
    .sp       (sp),
    .stk_full (stk_full),
    .stk_empty(stk_empty),
    .stk_err  (stk_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic wr, input logic ac, input logic [12:0] addr);
    PC_en   = en;
    PC_wr   = wr;
    acall   = ac;
    ir_addr = addr;
    tick();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 13'h0);
  endtask

  task automatic check_state(input string tag, input logic [12:0] e_pc,
                             input logic [3:0] e_sp, input logic e_err);
    n_total++;
    assert (pc_addr === e_pc) n_pass++;
    else $error("FAIL %s pc_addr observed=%h expected=%h", tag, pc_addr, e_pc);
    n_total++;
    assert (sp === e_sp) n_pass++;
    else $error("FAIL %s sp observed=%0d expected=%0d", tag, sp, e_sp);
    n_total++;
    assert (stk_err === e_err) n_pass++;
    else $error("FAIL %s stk_err observed=%b expected=%b", tag, stk_err, e_err);
    n_total++;
    assert (stk_empty === (e_sp == 4'd0)) n_pass++;
    else $error("FAIL %s stk_empty observed=%b expected=%b", tag, stk_empty, e_sp == 4'd0);
    n_total++;
    assert (stk_full === (e_sp == 4'd8)) n_pass++;
    else $error("FAIL %s stk_full observed=%b expected=%b", tag, stk_full, e_sp == 4'd8);
  endtask

  task automatic check_ret(input string tag, input logic [12:0] e_ret);
    n_total++;
    assert (ret_addr === e_ret) n_pass++;
    else $error("FAIL %s ret_addr observed=%h expected=%h", tag, ret_addr, e_ret);
  endtask

  initial begin
    rst = 1'b0;
    PC_en = 1'b0; PC_wr = 1'b0; acall = 1'b0; ir_addr = '0;
    tick();
    tick();
    check_state("reset", 13'h000, 4'd0, 1'b0);
    check_ret("reset", 13'h000);
    rst = 1'b1;

    // Level increment for five cycles.
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, 13'h0);
      check_state($sformatf("inc%0d", i), 13'(i), 4'd0, 1'b0);
    end

    // Held ACALL pushes once, then a RET pulse returns.
    drive(1'b0, 1'b1, 1'b1, 13'h120);
    check_state("acall", 13'h120, 4'd1, 1'b0);
    check_ret("acall", 13'h005);
    drive(1'b0, 1'b1, 1'b1, 13'h120);
    drive(1'b0, 1'b1, 1'b1, 13'h120);
    check_state("acall_held", 13'h120, 4'd1, 1'b0);
    idle();
    drive(1'b0, 1'b0, 1'b1, 13'h0);
    check_state("ret", 13'h005, 4'd0, 1'b0);
    idle();

    // Nested calls from 0x001, 0x011, 0x021.
    drive(1'b0, 1'b1, 1'b0, 13'h001);
    check_state("jmp1", 13'h001, 4'd0, 1'b0);
    idle();
    drive(1'b0, 1'b1, 1'b1, 13'h010);
    check_ret("nest1", 13'h001);
    idle();
    drive(1'b1, 1'b0, 1'b0, 13'h0);
    drive(1'b0, 1'b1, 1'b1, 13'h020);
    check_ret("nest2", 13'h011);
    idle();
    drive(1'b1, 1'b0, 1'b0, 13'h0);
    drive(1'b0, 1'b1, 1'b1, 13'h030);
    check_state("nest3", 13'h030, 4'd3, 1'b0);
    check_ret("nest3", 13'h021);
    idle();
    drive(1'b0, 1'b0, 1'b1, 13'h0);
    check_state("unnest3", 13'h021, 4'd2, 1'b0);
    idle();
    drive(1'b0, 1'b0, 1'b1, 13'h0);
    check_state("unnest2", 13'h011, 4'd1, 1'b0);
    idle();
    drive(1'b0, 1'b0, 1'b1, 13'h0);
    check_state("unnest1", 13'h001, 4'd0, 1'b0);
    idle();

    // Fill to DEPTH, then overflow.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 1'b1, 13'(13'h100 + i));
      idle();
    end
    check_state("filled", 13'h107, 4'd8, 1'b0);
    check_ret("filled", 13'h106);
    drive(1'b0, 1'b1, 1'b1, 13'h1AA);
    check_state("overflow", 13'h107, 4'd8, 1'b1);
    idle();
    drive(1'b0, 1'b0, 1'b1, 13'h0);
    check_state("drain_first", 13'h106, 4'd7, 1'b1);
    idle();
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b0, 1'b1, 13'h0);
      idle();
    end
    check_state("drained", 13'h001, 4'd0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 13'h0);
    check_state("underflow", 13'h001, 4'd0, 1'b1);
    idle();

    // Wraparound and JMP priority over PC_en.
    drive(1'b0, 1'b1, 1'b0, 13'h1FFF);
    idle();
    drive(1'b1, 1'b0, 1'b0, 13'h0);
    check_state("wrap", 13'h0000, 4'd0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 13'h0AA);
    check_state("jmp_wins", 13'h0AA, 4'd0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 13'h155);
    check_state("held_wr_inc", 13'h0AB, 4'd0, 1'b1);
    idle();

    // Build sp=3 at pc=0x040, then reset with acall high.
    drive(1'b0, 1'b1, 1'b1, 13'h200);
    idle();
    drive(1'b0, 1'b1, 1'b1, 13'h300);
    idle();
    drive(1'b0, 1'b1, 1'b1, 13'h040);
    idle();
    check_state("pre_reset", 13'h040, 4'd3, 1'b1);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 13'h0);
    check_state("mid_reset", 13'h000, 4'd0, 1'b0);
    check_ret("mid_reset", 13'h000);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 13'h0);
    check_state("post_reset_ret", 13'h000, 4'd0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 13'h0);
    check_state("post_reset_held", 13'h000, 4'd0, 1'b1);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
